// File: rtl/alu_dec_writeback_if.sv
// ALU-to-writeback bus: the ALU result bundle going in, plus busy and the
// registered carry returned to the ALU.
interface alu_dec_writeback_if;
    logic       alu_valid;
    logic [7:0] alu_out;
    logic [3:0] flags_in;     // {n,v,z,c}
    logic       half_carry;
    logic       dec_add;
    logic       dec_sub;
    logic [1:0] dest;         // 00 none, 01 A, 10 X, 11 Y
    logic [3:0] flag_mask;    // {n,v,z,c} bits of P to update
    logic       busy;
    logic       c_out;

    modport master (
        output alu_valid, alu_out, flags_in, half_carry,
        output dec_add, dec_sub, dest, flag_mask,
        input  busy, c_out
    );

    modport slave (
        input  alu_valid, alu_out, flags_in, half_carry,
        input  dec_add, dec_sub, dest, flag_mask,
        output busy, c_out
    );
endinterface

// File: rtl/alu_dec_writeback.sv
// ALU writeback stage: captures an ALU result, applies one cycle of NMOS-style
// BCD correction for decimal ADC/SBC, then writes A/X/Y and the masked NVZC flags.
module alu_dec_writeback #(
    parameter logic [3:0] RESET_P   = 4'b0000,
    parameter logic [7:0] RESET_REG = 8'h00
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_dec_writeback_if.slave alu,
    output logic               wb_valid,
    output logic [7:0]         reg_a,
    output logic [7:0]         reg_x,
    output logic [7:0]         reg_y,
    output logic [3:0]         p_nvzc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADJ  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0] cap_res;
    logic [3:0] cap_flags;
    logic       cap_hc;
    logic       cap_dec_add;
    logic       cap_dec_sub;
    logic [1:0] cap_dest;
    logic [3:0] cap_mask;

    logic       take;
    logic       is_dec;
    logic [3:0] lo_adj;
    logic [3:0] hi_adj;
    logic [7:0] adj_res;

    // Both decimal strobes at once is treated as a plain binary op.
    assign is_dec = alu.dec_add ^ alu.dec_sub;
    assign take   = (state == IDLE) && alu.alu_valid;

    assign alu.busy  = (state != IDLE);
    assign alu.c_out = p_nvzc[0];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (alu.alu_valid) state_next = is_dec ? ADJ : WB;
            ADJ:     state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Nibble-wise correction; each nibble wraps on its own, no inter-nibble carry.
    always_comb begin
        lo_adj = 4'h0;
        hi_adj = 4'h0;
        if (cap_dec_add) begin
            if (cap_hc)        lo_adj = 4'h6;
            if (cap_flags[0])  hi_adj = 4'h6;
        end else if (cap_dec_sub) begin
            if (!cap_hc)       lo_adj = 4'hA;
            if (!cap_flags[0]) hi_adj = 4'hA;
        end
        adj_res = {cap_res[7:4] + hi_adj, cap_res[3:0] + lo_adj};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_res     <= 8'h00;
            cap_flags   <= 4'h0;
            cap_hc      <= 1'b0;
            cap_dec_add <= 1'b0;
            cap_dec_sub <= 1'b0;
            cap_dest    <= 2'b00;
            cap_mask    <= 4'h0;
        end else if (take) begin
            cap_res     <= alu.alu_out;
            cap_flags   <= alu.flags_in;
            cap_hc      <= alu.half_carry;
            cap_dec_add <= alu.dec_add & ~alu.dec_sub;
            cap_dec_sub <= alu.dec_sub & ~alu.dec_add;
            cap_dest    <= alu.dest;
            cap_mask    <= alu.flag_mask;
        end else if (state == ADJ) begin
            // Flags are deliberately left as captured from the binary result.
            cap_res     <= adj_res;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_a    <= RESET_REG;
            reg_x    <= RESET_REG;
            reg_y    <= RESET_REG;
            p_nvzc   <= RESET_P;
            wb_valid <= 1'b0;
        end else begin
            wb_valid <= (state == WB);
            if (state == WB) begin
                case (cap_dest)
                    2'b01:   reg_a <= cap_res;
                    2'b10:   reg_x <= cap_res;
                    2'b11:   reg_y <= cap_res;
                    default: ;
                endcase
                p_nvzc <= (p_nvzc & ~cap_mask) | (cap_flags & cap_mask);
            end
        end
    end

endmodule

// File: tb/tb_alu_dec_writeback.sv
// Bench for alu_dec_writeback: directed scenarios then randomized ops, all
// compared against a nibble-arithmetic model of the writeback stage.
module tb_alu_dec_writeback;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wb_valid;
    logic [7:0] reg_a, reg_x, reg_y;
    logic [3:0] p_nvzc;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] m_a, m_x, m_y;
    logic [3:0] m_p;

    alu_dec_writeback_if bus ();

    alu_dec_writeback #(
        .RESET_P  (4'b0000),
        .RESET_REG(8'h00)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .alu     (bus),
        .wb_valid(wb_valid),
        .reg_a   (reg_a),
        .reg_x   (reg_x),
        .reg_y   (reg_y),
        .p_nvzc  (p_nvzc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] bcd_fix(input logic [7:0] r, input logic hc, input logic c,
                                           input logic da, input logic ds);
        int lo, hi;
        lo = r % 16;
        hi = r / 16;
        if (da && !ds) begin
            if (hc) lo = lo + 6;
            if (c)  hi = hi + 6;
        end else if (ds && !da) begin
            if (!hc) lo = lo + 10;
            if (!c)  hi = hi + 10;
        end
        return 8'((hi % 16) * 16 + (lo % 16));
    endfunction

    task automatic model_write(input logic [7:0] r, input logic [3:0] f, input logic hc,
                               input logic da, input logic ds, input logic [1:0] d,
                               input logic [3:0] m);
        logic [7:0] res;
        res = bcd_fix(r, hc, f[0], da, ds);
        if (d == 2'd1) m_a = res;
        if (d == 2'd2) m_x = res;
        if (d == 2'd3) m_y = res;
        for (int i = 0; i < 4; i++)
            if (m[i]) m_p[i] = f[i];
    endtask

    task automatic check_regs(input string tag);
        check({tag, " reg_a"}, reg_a, m_a);
        check({tag, " reg_x"}, reg_x, m_x);
        check({tag, " reg_y"}, reg_y, m_y);
        check({tag, " p_nvzc"}, {4'h0, p_nvzc}, {4'h0, m_p});
        check({tag, " c_out"}, {7'h0, bus.c_out}, {7'h0, m_p[0]});
    endtask

    task automatic drive(input logic [7:0] r, input logic [3:0] f, input logic hc,
                         input logic da, input logic ds, input logic [1:0] d,
                         input logic [3:0] m);
        bus.alu_valid  = 1'b1;
        bus.alu_out    = r;
        bus.flags_in   = f;
        bus.half_carry = hc;
        bus.dec_add    = da;
        bus.dec_sub    = ds;
        bus.dest       = d;
        bus.flag_mask  = m;
    endtask

    // Called #1 after a posedge; returns #1 after the write edge (wb_valid cycle).
    task automatic run_op(input string tag, input logic [7:0] r, input logic [3:0] f,
                          input logic hc, input logic da, input logic ds,
                          input logic [1:0] d, input logic [3:0] m);
        drive(r, f, hc, da, ds, d, m);
        @(posedge clk); #1;
        bus.alu_valid = 1'b0;
        bus.alu_out   = ~r;
        check({tag, " busy after capture"}, {7'h0, bus.busy}, 8'h01);
        check({tag, " reg_a before write"}, reg_a, m_a);
        if (da ^ ds) begin
            @(posedge clk); #1;
            check({tag, " busy in adj"}, {7'h0, bus.busy}, 8'h01);
            check({tag, " wb_valid early"}, {7'h0, wb_valid}, 8'h00);
        end
        @(posedge clk); #1;
        model_write(r, f, hc, da, ds, d, m);
        check_regs(tag);
        check({tag, " wb_valid"}, {7'h0, wb_valid}, 8'h01);
        check({tag, " busy idle"}, {7'h0, bus.busy}, 8'h00);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_out = 8'h00;
        bus.flags_in = 4'h0;
        bus.half_carry = 1'b0;
        bus.dec_add = 1'b0;
        bus.dec_sub = 1'b0;
        bus.dest = 2'b00;
        bus.flag_mask = 4'h0;
        m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_p = 4'h0;

        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");
        check("reset busy", {7'h0, bus.busy}, 8'h00);
        check("reset wb_valid", {7'h0, wb_valid}, 8'h00);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Binary ADC into A
        run_op("bin", 8'h85, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd1, 4'b1111);
        @(posedge clk); #1;
        check("bin wb_valid drop", {7'h0, wb_valid}, 8'h00);

        // Decimal add: no correction, then per-nibble wrap giving 70
        run_op("dec_add0", 8'h7B, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'b1111);
        check("dec_add0 value", reg_a, 8'h7B);
        run_op("dec_add1", 8'h1A, 4'b0001, 1'b1, 1'b1, 1'b0, 2'd1, 4'b1111);
        check("dec_add1 value", reg_a, 8'h70);

        // Decimal sub
        run_op("dec_sub", 8'hF5, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1111);
        check("dec_sub value", reg_a, 8'h95);

        // Both decimal strobes: binary path into X
        run_op("dec_both", 8'h3C, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0001);

        // Reset mid-ADJ aborts the op
        drive(8'h99, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd3, 4'b1111);
        @(posedge clk); #1;
        bus.alu_valid = 1'b0;
        check("rst_mid busy", {7'h0, bus.busy}, 8'h01);
        reset_n = 1'b0;
        #1;
        m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_p = 4'h0;
        check_regs("rst_mid");
        check("rst_mid busy cleared", {7'h0, bus.busy}, 8'h00);
        check("rst_mid wb_valid", {7'h0, wb_valid}, 8'h00);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_regs("rst_release");
        check("rst_release wb_valid", {7'h0, wb_valid}, 8'h00);

        // alu_valid held three cycles: 1st and 3rd captured, 2nd ignored
        drive(8'h11, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 4'b1111);
        @(posedge clk); #1;
        drive(8'h22, 4'b1100, 1'b0, 1'b0, 1'b0, 2'd1, 4'b1111);
        @(posedge clk); #1;
        m_a = 8'h11; m_p = 4'b0000;
        check("hold op1 reg_a", reg_a, m_a);
        check("hold op1 wb_valid", {7'h0, wb_valid}, 8'h01);
        drive(8'h33, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd1, 4'b1111);
        @(posedge clk); #1;
        bus.alu_valid = 1'b0;
        check("hold op3 busy", {7'h0, bus.busy}, 8'h01);
        check("hold op2 ignored", reg_a, 8'h11);
        check("hold wb_valid low", {7'h0, wb_valid}, 8'h00);
        @(posedge clk); #1;
        m_a = 8'h33; m_p = 4'b0010;
        check_regs("hold op3");

        // dest none, mask only z
        run_op("pre_mask", 8'h5A, 4'b1101, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1111);
        run_op("mask_z", 8'hEE, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010);
        check("mask_z p", {4'h0, p_nvzc}, 8'h0F);

        // Randomized ops with random gaps (gap 0 is back-to-back)
        for (int k = 0; k < 40; k++) begin
            logic [1:0] dsel;
            dsel = 2'($urandom_range(3, 0));
            run_op("rand", 8'($urandom_range(255, 0)), 4'($urandom_range(15, 0)),
                   1'($urandom_range(1, 0)), dsel[0], dsel[1],
                   2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)));
            repeat ($urandom_range(2, 0)) begin
                @(posedge clk); #1;
                check("rand idle wb_valid", {7'h0, wb_valid}, 8'h00);
                check("rand idle busy", {7'h0, bus.busy}, 8'h00);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
